// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial transmit path.
//   tx_state_t  : transmitter FSM states
//   LINE_IDLE   : level of the serial line between frames (also the stop bit)
//   START_LEVEL : level of the start bit
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam logic LINE_IDLE   = 1'b1;
   localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_tx_if.sv
// Word handshake between a producer and the serial transmitter.
//   tx_data  : word to send, sampled only when tx_valid && tx_ready
//   tx_valid : producer has a word on tx_data
//   tx_ready : transmitter can accept a word this cycle
// Modports: master = producer side, slave = transmitter side.
interface serial_tx_if #(
   parameter int unsigned DATA_W = 8
);

   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/bit_timer.sv
// Bit-period divider for the serial transmitter.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   run      : count this cycle (frame in progress and enabled)
//   clear    : force the divider back to zero
//   bit_tick : one-cycle pulse in the last clk cycle of each bit period
module bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic bit_tick
);

   localparam int unsigned DivW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [DivW-1:0] DivMax = DivW'(CLKS_PER_BIT - 1);

   logic [DivW-1:0] div_q, div_d;

   // Tick only while running, so a paused divider never ends a bit.
   assign bit_tick = run && (div_q == DivMax);

   always_comb begin
      div_d = div_q;
      if (clear) begin
         div_d = '0;
      end else if (bit_tick) begin
         div_d = '0;
      end else if (run) begin
         div_d = div_q + DivW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit (low), DATA_W data bits LSB
// first, stop bit (high); each bit held CLKS_PER_BIT cycles on tx_out.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   enable : low pauses the block (frame stretched, no accepts)
//   tx_if  : word handshake (slave side)
//   tx_out : registered serial line, idles high
//   busy   : a frame is in progress
module serial_tx
   import serial_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   serial_tx_if.slave   tx_if,
   output logic         tx_out,
   output logic         busy
);

   localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              tx_out_q, tx_out_d;
   logic              accept;
   logic              run;
   logic              bit_tick;

   assign tx_if.tx_ready = (state_q == IDLE) && enable;
   assign accept         = tx_if.tx_valid && tx_if.tx_ready;
   assign busy           = (state_q != IDLE);
   assign run            = busy && enable;
   assign tx_out         = tx_out_q;

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .clear    (accept),
      .bit_tick (bit_tick)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
               shift_d = tx_if.tx_data;
               cnt_d   = '0;
            end
         end
         START: begin
            if (bit_tick) state_d = DATA;
         end
         DATA: begin
            if (bit_tick) begin
               if (cnt_q == CntLast) begin
                  state_d = STOP;
               end else begin
                  shift_d = shift_q >> 1;
                  cnt_d   = cnt_q + CntW'(1);
               end
            end
         end
         STOP: begin
            if (bit_tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level is decoded from the next state so it registers together with
   // the state change; the start bit appears the cycle after the accept edge.
   always_comb begin
      tx_out_d = LINE_IDLE;
      unique case (state_d)
         IDLE:    tx_out_d = LINE_IDLE;
         START:   tx_out_d = START_LEVEL;
         DATA:    tx_out_d = shift_d[0];
         STOP:    tx_out_d = LINE_IDLE;
         default: tx_out_d = LINE_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         tx_out_q <= LINE_IDLE;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         tx_out_q <= tx_out_d;
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one 8-bit/4-clk instance and one 4-bit/1-clk
// instance; frames are checked cycle by cycle against hand-written levels.
module tb_serial_tx;
   import serial_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic enable;

   logic tx_out1, busy1;
   logic tx_out2, busy2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_tx_if #(.DATA_W(8)) if1 ();
   serial_tx_if #(.DATA_W(4)) if2 ();

   serial_tx #(
      .DATA_W       (8),
      .CLKS_PER_BIT (4)
   ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .tx_if  (if1),
      .tx_out (tx_out1),
      .busy   (busy1)
   );

   serial_tx #(
      .DATA_W       (4),
      .CLKS_PER_BIT (1)
   ) u_dut_small (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .tx_if  (if2),
      .tx_out (tx_out2),
      .busy   (busy2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // {tx_out, busy, tx_ready} of the selected instance
   function automatic logic [2:0] obs(input bit sel);
      if (sel) return {tx_out2, busy2, if2.tx_ready};
      return {tx_out1, busy1, if1.tx_ready};
   endfunction

   // Called at the first negedge after the accepting edge. lv holds the
   // expected line level per bit ('0'/'1'), start and stop included.
   // pulse_at: frame cycle at which a 0x00 word is offered on if1.
   // stall_at/stall_len: frame cycle at which enable drops, and for how long.
   task automatic check_frame(input string tag, input bit sel, input string lv,
                              input int cpb, input int pulse_at,
                              input int stall_at, input int stall_len);
      int   t = 0;
      logic e;
      for (int b = 0; b < lv.len(); b++) begin
         e = (lv[b] == 8'h31);
         for (int c = 0; c < cpb; c++) begin
            check($sformatf("%s bit%0d cyc%0d", tag, b, c), 32'(obs(sel)), {29'd0, e, 2'b10});
            if (t == pulse_at) begin
               if1.tx_valid = 1'b1;
               if1.tx_data  = 8'h00;
            end else if (t == pulse_at + 1) begin
               if1.tx_valid = 1'b0;
            end
            if (t == stall_at) begin
               enable = 1'b0;
               for (int s = 0; s < stall_len; s++) begin
                  @(negedge clk);
                  check($sformatf("%s stall%0d", tag, s), 32'(obs(sel)), {29'd0, e, 2'b10});
               end
               enable = 1'b1;
            end
            @(negedge clk);
            t++;
         end
      end
      check({tag, " idle after"}, 32'(obs(sel)), 32'b101);
   endtask

   task automatic offer1(input logic [7:0] d);
      if1.tx_data  = d;
      if1.tx_valid = 1'b1;
      check("ready before accept", 32'(if1.tx_ready), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      enable       = 1'b1;
      if1.tx_valid = 1'b0;
      if1.tx_data  = '0;
      if2.tx_valid = 1'b0;
      if2.tx_data  = '0;

      // Reset state
      @(negedge clk);
      check("reset out/busy/ready", 32'(obs(0)), 32'b101);
      check("reset small", 32'(obs(1)), 32'b101);
      check("reset state", 32'(u_dut.state_q), 32'(IDLE));
      rst = 1'b0;

      // 0xA5: 0 | 1,0,1,0,0,1,0,1 | 1
      offer1(8'hA5);
      if1.tx_valid = 1'b0;
      check_frame("a5", 1'b0, "0101001011", 4, -10, -10, 0);

      // 0x3C then 0xFF with tx_valid held: exactly one idle cycle between
      offer1(8'h3C);
      if1.tx_data = 8'hFF;
      check_frame("3c", 1'b0, "0001111001", 4, -10, -10, 0);
      @(negedge clk);
      if1.tx_valid = 1'b0;
      check_frame("ff", 1'b0, "0111111111", 4, -10, -10, 0);

      // 0xC3 with a 0x00 offered mid-frame: ignored
      offer1(8'hC3);
      if1.tx_valid = 1'b0;
      check_frame("c3", 1'b0, "0110000111", 4, 12, -10, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("no queued word", 32'(obs(0)), 32'b101);
      end

      // 0x81, enable low for 10 cycles from the 2nd cycle of data bit 3
      offer1(8'h81);
      if1.tx_valid = 1'b0;
      check_frame("81", 1'b0, "0100000011", 4, -10, 17, 10);

      // enable low in IDLE: not ready, no accept
      enable = 1'b0;
      if1.tx_data  = 8'h00;
      if1.tx_valid = 1'b1;
      #1;
      check("ready while disabled", 32'(if1.tx_ready), 32'd0);
      @(negedge clk);
      check("no accept while disabled", 32'(obs(0)), 32'b100);
      if1.tx_valid = 1'b0;
      enable = 1'b1;
      @(negedge clk);

      // 0x55 with asynchronous reset mid-DATA
      offer1(8'h55);
      if1.tx_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("pre-reset busy", 32'(busy1), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async rst out/busy/ready", 32'(obs(0)), 32'b101);
      check("async rst state", 32'(u_dut.state_q), 32'(IDLE));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready after rst", 32'(if1.tx_ready), 32'd1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("nothing resumed", 32'(obs(0)), 32'b101);
      end

      // Small instance, CLKS_PER_BIT=1, DATA_W=4, word 0x9
      if2.tx_data  = 4'h9;
      if2.tx_valid = 1'b1;
      @(negedge clk);
      if2.tx_valid = 1'b0;
      check_frame("small 9", 1'b1, "010011", 1, -10, -10, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
